// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: op encodings, FSM states,
// access sizes and small op-decode helpers.
package mem_access_pkg;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    // Data memory is 12 KiB; anything at or above this is out of range.
    localparam logic [31:0] DM_SIZE_BYTES = 32'h0000_3000;

    typedef enum logic {IDLE, MERGE_WR} state_t;

    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_t;

    function automatic size_t op_size(input logic [2:0] op);
        case (op)
            OP_LW, OP_SW:         return SIZE_WORD;
            OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
            default:              return SIZE_BYTE;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_LH) || (op == OP_LB);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
        case (op_size(op))
            SIZE_WORD: return lane != 2'b00;
            SIZE_HALF: return lane[0];
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Combinational lane logic: byte/half extract with sign or zero extension,
// and byte/half insert of store data into an existing word.
module mem_lane
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half and extend it to a full load result.
    always_comb begin
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default:   load_data = word;
        endcase
    end

    // Replace the addressed lane of the word with the low bits of store_data.
    always_comb begin
        merged = word;
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = store_data[7:0];
                    2'd1:    merged[15:8]  = store_data[7:0];
                    2'd2:    merged[23:16] = store_data[7:0];
                    default: merged[31:24] = store_data[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane[1]) merged[31:16] = store_data[15:0];
                else         merged[15:0]  = store_data[15:0];
            end
            default: merged = store_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage memory access unit. Loads and word stores complete in one cycle;
// byte/half stores read-merge in cycle 1 and write the registered merge in
// cycle 2, stalling the pipeline for exactly one cycle.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic [31:0] dm_pc,
    output logic        dm_write,
    output logic [13:0] dm_addr_byte,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    state_t      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [13:0] addr_q, addr_d;
    logic [31:0] pc_q, pc_d;

    size_t       acc_size;
    logic        acc_err;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    assign acc_size = op_size(req_op);
    assign acc_err  = (req_addr >= DM_SIZE_BYTES) || misaligned(req_op, req_addr[1:0]);

    mem_lane u_lane (
        .word       (dm_rdata),
        .lane       (req_addr[1:0]),
        .size       (acc_size),
        .sign_ext   (op_is_signed(req_op)),
        .store_data (req_wdata),
        .load_data  (lane_load),
        .merged     (lane_merged)
    );

    // Decode the current request / pending merge into outputs and next state.
    always_comb begin
        state_d      = state_q;
        merge_d      = merge_q;
        addr_d       = addr_q;
        pc_d         = pc_q;
        stall        = 1'b0;
        dm_write     = 1'b0;
        rdata        = '0;
        rdata_valid  = 1'b0;
        addr_err     = 1'b0;
        dm_addr_byte = req_addr[13:0];
        dm_pc        = req_pc;
        dm_wdata     = req_wdata;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (acc_err) begin
                            addr_err = 1'b1;
                        end else if (!op_is_store(req_op)) begin
                            rdata       = lane_load;
                            rdata_valid = 1'b1;
                        end else if (req_op == OP_SW) begin
                            dm_write = 1'b1;
                        end else begin
                            // Sub-word store: capture the merge now, write it next cycle.
                            stall   = 1'b1;
                            merge_d = lane_merged;
                            addr_d  = req_addr[13:0];
                            pc_d    = req_pc;
                            state_d = MERGE_WR;
                        end
                    end
                end
                MERGE_WR: begin
                    // Request inputs are held by the requester and ignored here.
                    dm_write     = 1'b1;
                    dm_wdata     = merge_q;
                    dm_addr_byte = addr_q;
                    dm_pc        = pc_q;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and merge registers; reset drops any pending sub-word store.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            merge_q <= '0;
            addr_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  the M-stage instruction is a memory op.
REQ-005 req_op  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
REQ-006 req_addr  in  32  byte address (base+offset).
REQ-007 req_wdata  in  32  store source (rt value), right-aligned.
REQ-008 req_pc  in  32  PC of the M-stage instruction.
REQ-009 stall  out  1  hold the M stage and all earlier stages this cycle.
REQ-010 rdata  out  32  extended load result.
REQ-011 rdata_valid  out  1  rdata is meaningful this cycle.
REQ-012 addr_err  out  1  misaligned or out-of-range access.
REQ-013 dm_pc  out  32  PC forwarded to the data memory for its write trace.
REQ-014 dm_write  out  1  word write strobe to the data memory; it commits on the rising edge.
REQ-015 dm_addr_byte  out  14  byte address to the data memory (bits 13:0).
REQ-016 dm_wdata  out  32  full word to write.
REQ-017 dm_rdata  in  32  combinational word read of dm_addr_byte[13:2].

Function
REQ-018 The block SHALL implement two states: IDLE and MERGE_WR.
REQ-019 Range: any access with req_addr >= 0x3000 (12 KiB) SHALL assert addr_err.
REQ-020 Alignment: addr_err SHALL also be asserted for lw/sw when addr[1:0]!=0, and for lh/lhu/sh when addr[0]!=0.
REQ-021 On an addr_err access, the block SHALL hold dm_write=0, rdata=0, rdata_valid=0 and stall=0; addr_err SHALL be combinational and only asserted when req_valid=1.
REQ-022 Loads in IDLE: the block SHALL drive dm_addr_byte=req_addr[13:0] and dm_write=0, produce rdata combinationally in the same cycle with rdata_valid=1 and stall=0, and take zero extra cycles.
REQ-023 Load lane select: the block SHALL extract the byte at lane addr[1:0] and the halfword at lane addr[1]; lb/lh SHALL sign-extend and lbu/lhu SHALL zero-extend.
REQ-024 sw in IDLE: the block SHALL drive dm_write=1, dm_wdata=req_wdata, dm_pc=req_pc and stall=0, with the write committing on that edge.
REQ-025 sb/sh in IDLE (cycle 1): the block SHALL drive dm_write=0 and stall=1, register the merge of dm_rdata with the low byte/half of req_wdata into the addressed lane, latch the address and PC, and go to MERGE_WR.
REQ-026 MERGE_WR (cycle 2): the block SHALL drive dm_write=1, dm_wdata=merged register, dm_addr_byte and dm_pc from the latched values, and stall=0, then go to IDLE; a sub-word store therefore costs exactly one stall cycle.
REQ-027 The merged word SHALL be registered so that the DM read -> merge -> DM write path is never combinational.
REQ-028 In MERGE_WR, the req_* inputs SHALL be ignored; the requester holds them stable, and the bench checks this.
REQ-029 A request in the cycle after MERGE_WR SHALL be handled as a fresh IDLE request; a load of the just-stored word SHALL see the merged value.
REQ-030 With req_valid=0, the block SHALL drive dm_write=0, stall=0, rdata_valid=0 and rdata=0.
REQ-031 The block SHALL not produce a dm_write in any cycle other than sw-IDLE or MERGE_WR.

Reset
REQ-032 When reset=1 at an edge, the state SHALL become IDLE and the merge, address and PC registers SHALL clear to 0.
REQ-033 While reset=1, the block SHALL force dm_write=0, stall=0, rdata_valid=0 and addr_err=0.
REQ-034 A reset asserted while in MERGE_WR SHALL abort the pending sub-word store, so that no write ever occurs.

Structure
REQ-035 A shared package mem_access_pkg SHALL hold the req_op encodings, the state enum {IDLE, MERGE_WR} and DM_SIZE_BYTES=0x3000.
REQ-036 The lane logic SHALL be one combinational sub-module, mem_lane, which provides byte/half extract with extension and byte/half insert into a word; the FSM and registers SHALL stay in the top level.

Verification
REQ-037 lw @0x0004 with DM word 0x8899AABB -> rdata=0x8899AABB, rdata_valid=1, stall=0 in the same cycle.
REQ-038 lb @0x0007 and lbu @0x0007 on word 0x8899AABB -> lb gives rdata=0xFFFFFF88 and lbu gives 0x00000088.
REQ-039 sb @0x0005, wdata=0x12345678, on word 0xAABBCCDD -> cycle 1 has stall=1 and dm_write=0; cycle 2 has dm_write=1 and dm_wdata=0xAABB78DD; a following lw @0x0004 returns 0xAABB78DD.
REQ-040 sh @0x0003 and lw @0x3000 -> addr_err=1, dm_write=0, stall=0, and the memory is unchanged.
REQ-041 sh @0x0002, wdata=0x0000BEEF, with reset asserted during MERGE_WR -> no dm_write, state IDLE, and the word is unchanged.
REQ-042 Back-to-back sw @0x0000 then sb @0x0000 -> a single write of 0x11223344 followed by exactly one stall cycle and a write of 0x112233xx with the new low byte.
